// File: rtl/cm_pkg.sv
// cm_pkg: shared state type and round-robin helper for the cm_sort family
package cm_pkg;
  typedef enum logic [1:0] {RUN, DRAIN, IDLE} t_sort_arb_state;
  localparam int unsigned RR_MAXW = 32;
  // one-hot first set bit of req at or after ptr, wrapping within n (ptr < n <= RR_MAXW)
  function automatic logic [RR_MAXW-1:0] rr_pick(input logic [RR_MAXW-1:0] req, input int unsigned ptr,
                                                 input int unsigned n);
    logic [RR_MAXW-1:0] gnt;
    logic [RR_MAXW-1:0] sh;
    int unsigned idx;
    gnt = '0;
    for (int unsigned i = 0; i < RR_MAXW; i++) begin
      idx = ptr + i;
      idx = (idx >= n) ? idx - n : idx;
      sh = req >> idx;
      if (i < n && gnt == '0 && sh[0]) gnt = RR_MAXW'(1) << idx;
    end
    return gnt;
  endfunction
endpackage

// File: rtl/cm_sort.sv
// cm_sort: ascending sort of DCNT unsigned elements (index 0 lowest) followed by REG_CNT stages.
// Data-only pipeline; validity is tracked by the owner, so no reset is needed here.
module cm_sort #(
  parameter int DCNT    = 4,
  parameter int DWIDTH  = 8,
  parameter int REG_CNT = 2
) (
  input  logic                         i_clk,
  input  logic [DCNT-1:0][DWIDTH-1:0]  i_data,
  output logic [DCNT-1:0][DWIDTH-1:0]  o_data
);
  logic [DCNT-1:0][DWIDTH-1:0] w_sorted;
  logic [REG_CNT-1:0][DCNT-1:0][DWIDTH-1:0] r_pipe;
  always_comb begin
    w_sorted = i_data;
    for (int p = 0; p < DCNT; p++)
      for (int j = 0; j < DCNT - 1; j++)
        if (w_sorted[j] > w_sorted[j+1]) {w_sorted[j], w_sorted[j+1]} = {w_sorted[j+1], w_sorted[j]};
  end
  always_ff @(posedge i_clk) begin
    r_pipe[0] <= w_sorted;
    for (int s = 1; s < REG_CNT; s++) r_pipe[s] <= r_pipe[s-1];
  end
  assign o_data = r_pipe[REG_CNT-1];
endmodule

// File: rtl/cm_sort_rbuf.sv
// cm_sort_rbuf: tagged result FIFO; push and pop may coincide at any level, including full.
module cm_sort_rbuf #(
  parameter int DEPTH  = 4,
  parameter int TAGW   = 2,
  parameter int DCNT   = 4,
  parameter int DWIDTH = 8,
  localparam int OW = $clog2(DEPTH + 1),
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic                         i_clk,
  input  logic                         i_rst,
  input  logic                         i_push,
  input  logic [TAGW-1:0]              i_tag,
  input  logic [DCNT-1:0][DWIDTH-1:0]  i_data,
  input  logic                         i_pop,
  output logic                         o_vld,
  output logic [TAGW-1:0]              o_tag,
  output logic [DCNT-1:0][DWIDTH-1:0]  o_data,
  output logic [OW-1:0]                o_occ
);
  logic [TAGW-1:0] r_tag [DEPTH];
  logic [DCNT-1:0][DWIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0] r_wp, r_rp;
  logic [OW-1:0] r_occ;
  logic w_pop;
  assign o_occ  = r_occ;
  assign o_vld  = r_occ != '0;
  assign w_pop  = i_pop & o_vld;
  // outputs forced to zero while empty so reset and idle present clean values
  assign o_tag  = o_vld ? r_tag[r_rp] : '0;
  assign o_data = o_vld ? r_mem[r_rp] : '0;
  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      r_wp  <= '0;
      r_rp  <= '0;
      r_occ <= '0;
    end else begin
      if (i_push) r_wp <= (r_wp == AW'(DEPTH - 1)) ? '0 : r_wp + AW'(1);
      if (w_pop) r_rp <= (r_rp == AW'(DEPTH - 1)) ? '0 : r_rp + AW'(1);
      r_occ <= r_occ + OW'(i_push) - OW'(w_pop);
    end
  end
  always_ff @(posedge i_clk) begin
    if (i_push) begin
      r_mem[r_wp] <= i_data;
      r_tag[r_wp] <= i_tag;
    end
  end
endmodule

// File: rtl/cm_sort_arb.sv
// cm_sort_arb: round-robin sharing of one cm_sort between RCNT requesters, with credit flow
// control into a tagged result buffer and a flush FSM that drains before going idle.
module cm_sort_arb
  import cm_pkg::*;
#(
  parameter int RCNT       = 4,
  parameter int DCNT       = 4,
  parameter int DWIDTH     = 8,
  parameter int REG_CNT    = 2,
  parameter int RBUF_DEPTH = 4,
  localparam int TAGW = $clog2(RCNT)
) (
  input  logic                                  i_clk,
  input  logic                                  i_rst,
  input  logic [RCNT-1:0]                       i_req,
  input  logic [RCNT-1:0][DCNT-1:0][DWIDTH-1:0] i_data,
  output logic [RCNT-1:0]                       o_gnt,
  input  logic                                  i_flush,
  output logic                                  o_idle,
  output logic                                  o_vld,
  output logic [TAGW-1:0]                       o_tag,
  output logic [DCNT-1:0][DWIDTH-1:0]           o_data,
  input  logic                                  i_rdy
);
  localparam int OW = $clog2(RBUF_DEPTH + 1);
  localparam int IW = $clog2(REG_CNT + 1);
  localparam int CW = ((OW > IW) ? OW : IW) + 1;
  if (RBUF_DEPTH < REG_CNT + 1) begin : g_bad_depth
    $error("cm_sort_arb: RBUF_DEPTH must be >= REG_CNT+1");
  end
  t_sort_arb_state r_state, w_state_nx;
  logic [TAGW-1:0] r_ptr, w_idx;
  logic [IW-1:0] r_infl;
  logic [OW-1:0] w_occ;
  logic [REG_CNT-1:0] r_sv;
  logic [REG_CNT-1:0][TAGW-1:0] r_st;
  logic w_pop, w_push, w_acc, w_credit_ok;
  logic [DCNT-1:0][DWIDTH-1:0] w_sort_in, w_sort_out;
  assign w_pop  = o_vld & i_rdy;
  assign w_push = r_sv[REG_CNT-1];
  // a slot is reserved for every vector in the sorter, so the buffer can never overflow
  assign w_credit_ok = (CW'(w_occ) + CW'(r_infl) - CW'(w_pop)) < CW'(RBUF_DEPTH);
  assign o_idle = (r_infl == '0) && (w_occ == '0);
  assign o_gnt  = (r_state == RUN && !i_flush && w_credit_ok) ?
                  RCNT'(rr_pick(RR_MAXW'(i_req), 32'(r_ptr), RCNT)) : '0;
  assign w_acc  = |o_gnt;
  always_comb begin
    w_idx = '0;
    for (int r = 0; r < RCNT; r++) w_idx = o_gnt[r] ? TAGW'(r) : w_idx;
  end
  assign w_sort_in = i_data[w_idx];
  always_comb begin
    w_state_nx = r_state;
    case (r_state)
      RUN:     w_state_nx = i_flush ? DRAIN : RUN;
      DRAIN:   w_state_nx = o_idle ? IDLE : DRAIN;
      IDLE:    w_state_nx = (|i_req) ? RUN : IDLE;
      default: w_state_nx = RUN;
    endcase
  end
  // vectors caught in the sorter by reset are dropped simply by clearing their valid bits
  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      r_state <= RUN;
      r_ptr   <= '0;
      r_infl  <= '0;
      r_sv    <= '0;
      r_st    <= '0;
    end else begin
      r_state <= w_state_nx;
      if (w_acc) r_ptr <= (w_idx == TAGW'(RCNT - 1)) ? '0 : w_idx + TAGW'(1);
      r_infl <= r_infl + IW'(w_acc) - IW'(w_push);
      r_sv[0] <= w_acc;
      r_st[0] <= w_idx;
      for (int s = 1; s < REG_CNT; s++) begin
        r_sv[s] <= r_sv[s-1];
        r_st[s] <= r_st[s-1];
      end
    end
  end
  cm_sort #(.DCNT(DCNT), .DWIDTH(DWIDTH), .REG_CNT(REG_CNT)) u_sort (
    .i_clk (i_clk),
    .i_data(w_sort_in),
    .o_data(w_sort_out)
  );
  cm_sort_rbuf #(.DEPTH(RBUF_DEPTH), .TAGW(TAGW), .DCNT(DCNT), .DWIDTH(DWIDTH)) u_rbuf (
    .i_clk (i_clk),
    .i_rst (i_rst),
    .i_push(w_push),
    .i_tag (r_st[REG_CNT-1]),
    .i_data(w_sort_out),
    .i_pop (w_pop),
    .o_vld (o_vld),
    .o_tag (o_tag),
    .o_data(o_data),
    .o_occ (w_occ)
  );
endmodule
